// File: rtl/axil_arb2.sv
`default_nettype none
// ============================================================================
// axil_arb2 : round-robin arbiter sharing one AXI-lite slave between two
//             requesters, one complete read or write per grant.
// Revision  : 1.0
// ============================================================================
module axil_arb2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      sclk,
    input  logic                      reset,

    input  logic [2*ADDR_W-1:0]       s_awaddr_i,
    input  logic [1:0]                s_awvalid_i,
    output logic [1:0]                s_awready_o,
    input  logic [2*DATA_W-1:0]       s_wdata_i,
    input  logic [2*(DATA_W/8)-1:0]   s_wstrb_i,
    input  logic [1:0]                s_wvalid_i,
    output logic [1:0]                s_wready_o,
    output logic [3:0]                s_bresp_o,
    output logic [1:0]                s_bvalid_o,
    input  logic [1:0]                s_bready_i,
    input  logic [2*ADDR_W-1:0]       s_araddr_i,
    input  logic [1:0]                s_arvalid_i,
    output logic [1:0]                s_arready_o,
    output logic [2*DATA_W-1:0]       s_rdata_o,
    output logic [3:0]                s_rresp_o,
    output logic [1:0]                s_rvalid_o,
    input  logic [1:0]                s_rready_i,

    output logic [ADDR_W-1:0]         m_awaddr_o,
    output logic                      m_awvalid_o,
    input  logic                      m_awready_i,
    output logic [DATA_W-1:0]         m_wdata_o,
    output logic [DATA_W/8-1:0]       m_wstrb_o,
    output logic                      m_wvalid_o,
    input  logic                      m_wready_i,
    input  logic [1:0]                m_bresp_i,
    input  logic                      m_bvalid_i,
    output logic                      m_bready_o,
    output logic [ADDR_W-1:0]         m_araddr_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,
    input  logic [DATA_W-1:0]         m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o,

    output logic [1:0]                grant_o,
    output logic                      busy_o
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RD    = 3'd3,
        RDATA = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   g, g_nxt;
    logic   last, last_nxt;
    logic   aw_done, aw_done_nxt;
    logic   w_done, w_done_nxt;

    logic [1:0] req;
    logic       first;
    logic       winner;
    logic [1:0] gsel;

    logic aw_rdy, w_rdy, ar_rdy, b_vld, r_vld;
    logic aw_hs, w_hs;

    assign req    = s_awvalid_i | s_arvalid_i;
    assign first  = ~last;
    assign winner = req[first] ? first : last;
    assign gsel   = g ? 2'b10 : 2'b01;

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            g       <= 1'b0;
            last    <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            g       <= g_nxt;
            last    <= last_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        g_nxt       = g;
        last_nxt    = last;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        m_awvalid_o = 1'b0;
        m_wvalid_o  = 1'b0;
        m_bready_o  = 1'b0;
        m_arvalid_o = 1'b0;
        m_rready_o  = 1'b0;
        aw_rdy      = 1'b0;
        w_rdy       = 1'b0;
        ar_rdy      = 1'b0;
        b_vld       = 1'b0;
        r_vld       = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    g_nxt     = winner;
                    // a pending write wins over a read from the same requester
                    state_nxt = s_awvalid_i[winner] ? WR : RD;
                end
            end
            WR: begin
                m_awvalid_o = s_awvalid_i[g] & ~aw_done;
                aw_rdy      = m_awready_i & ~aw_done;
                m_wvalid_o  = s_wvalid_i[g] & ~w_done;
                w_rdy       = m_wready_i & ~w_done;
                aw_hs       = m_awvalid_o & m_awready_i;
                w_hs        = m_wvalid_o & m_wready_i;
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    state_nxt   = WRESP;
                end else begin
                    aw_done_nxt = aw_done | aw_hs;
                    w_done_nxt  = w_done | w_hs;
                end
            end
            WRESP: begin
                b_vld      = m_bvalid_i;
                m_bready_o = s_bready_i[g];
                if (m_bvalid_i && s_bready_i[g]) begin
                    last_nxt  = g;
                    state_nxt = IDLE;
                end
            end
            RD: begin
                m_arvalid_o = s_arvalid_i[g];
                ar_rdy      = m_arready_i;
                if (s_arvalid_i[g] && m_arready_i) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                r_vld      = m_rvalid_i;
                m_rready_o = s_rready_i[g];
                if (m_rvalid_i && s_rready_i[g]) begin
                    last_nxt  = g;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake signals of the non-granted requester stay at 0.
    assign s_awready_o = gsel & {2{aw_rdy}};
    assign s_wready_o  = gsel & {2{w_rdy}};
    assign s_arready_o = gsel & {2{ar_rdy}};
    assign s_bvalid_o  = gsel & {2{b_vld}};
    assign s_rvalid_o  = gsel & {2{r_vld}};

    assign busy_o  = (state != IDLE);
    assign grant_o = busy_o ? gsel : 2'b00;

    // Data paths are held at 0 while reset is asserted so every output clears at once.
    assign m_awaddr_o = !reset ? '0 : (g ? s_awaddr_i[ADDR_W +: ADDR_W] : s_awaddr_i[0 +: ADDR_W]);
    assign m_araddr_o = !reset ? '0 : (g ? s_araddr_i[ADDR_W +: ADDR_W] : s_araddr_i[0 +: ADDR_W]);
    assign m_wdata_o  = !reset ? '0 : (g ? s_wdata_i[DATA_W +: DATA_W] : s_wdata_i[0 +: DATA_W]);
    assign m_wstrb_o  = !reset ? '0 : (g ? s_wstrb_i[STRB_W +: STRB_W] : s_wstrb_i[0 +: STRB_W]);

    assign s_rdata_o = !reset ? '0 : (g ? {m_rdata_i, {DATA_W{1'b0}}} : {{DATA_W{1'b0}}, m_rdata_i});
    assign s_rresp_o = !reset ? '0 : (g ? {m_rresp_i, 2'b00} : {2'b00, m_rresp_i});
    assign s_bresp_o = !reset ? '0 : (g ? {m_bresp_i, 2'b00} : {2'b00, m_bresp_i});

endmodule
`default_nettype wire

// File: tb/tb_axil_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for axil_arb2: directed requester traffic, reactive slave model,
// per-requester expected-response queues checked by an independent monitor.
module tb_axil_arb2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic sclk  = 1'b0;
    logic reset = 1'b0;
    always #5 sclk = ~sclk;

    logic [2*AW-1:0] s_awaddr_i = '0;
    logic [1:0]      s_awvalid_i = '0;
    logic [1:0]      s_awready_o;
    logic [2*DW-1:0] s_wdata_i = '0;
    logic [2*SW-1:0] s_wstrb_i = '0;
    logic [1:0]      s_wvalid_i = '0;
    logic [1:0]      s_wready_o;
    logic [3:0]      s_bresp_o;
    logic [1:0]      s_bvalid_o;
    logic [1:0]      s_bready_i = 2'b11;
    logic [2*AW-1:0] s_araddr_i = '0;
    logic [1:0]      s_arvalid_i = '0;
    logic [1:0]      s_arready_o;
    logic [2*DW-1:0] s_rdata_o;
    logic [3:0]      s_rresp_o;
    logic [1:0]      s_rvalid_o;
    logic [1:0]      s_rready_i = 2'b11;

    logic [AW-1:0]   m_awaddr_o;
    logic            m_awvalid_o;
    logic            m_awready_i = 1'b1;
    logic [DW-1:0]   m_wdata_o;
    logic [SW-1:0]   m_wstrb_o;
    logic            m_wvalid_o;
    logic            m_wready_i = 1'b1;
    logic [1:0]      m_bresp_i = '0;
    logic            m_bvalid_i = 1'b0;
    logic            m_bready_o;
    logic [AW-1:0]   m_araddr_o;
    logic            m_arvalid_o;
    logic            m_arready_i = 1'b1;
    logic [DW-1:0]   m_rdata_i = '0;
    logic [1:0]      m_rresp_i = '0;
    logic            m_rvalid_i = 1'b0;
    logic            m_rready_o;
    logic [1:0]      grant_o;
    logic            busy_o;

    axil_arb2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .sclk(sclk), .reset(reset),
        .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
        .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
        .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
        .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    typedef struct {
        bit            is_rd;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    int            served[$];
    logic [AW-1:0] rdq0[$];
    logic [AW-1:0] rdq1[$];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         aw_stall = 0;
    logic [1:0] slv_bresp = '0;
    logic [1:0] slv_rresp = '0;

    logic [AW-1:0] f_addr0 [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [AW-1:0] f_addr1 [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
    logic [DW-1:0] f_data0 [4] = '{32'h0100C0DE, 32'h0104C0DE, 32'h0108C0DE, 32'h010CC0DE};
    logic [DW-1:0] f_data1 [4] = '{32'h0200C0DE, 32'h0204C0DE, 32'h0208C0DE, 32'h020CC0DE};

    wire [17:0] hs_bundle = {s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rvalid_o,
                             m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o,
                             busy_o, grant_o};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input bit rd, input logic [DW-1:0] d, input logic [1:0] r);
        exp_t e;
        e.is_rd = rd;
        e.data  = d;
        e.resp  = r;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    function automatic logic [DW-1:0] rd_table(input logic [AW-1:0] a);
        case (a)
            32'h4:   return 32'h11111111;
            32'h8:   return 32'h22222222;
            default: return {a[15:0], 16'hC0DE};
        endcase
    endfunction

    task automatic pop_cmp(input int i, input bit rd, input logic [DW-1:0] d, input logic [1:0] r);
        exp_t e;
        int   sz;
        sz = (i == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp req%0d: got rd=%0d with nothing expected", i, rd);
            return;
        end
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        served.push_back(i);
        check($sformatf("resp_kind_r%0d", i), rd, e.is_rd);
        if (rd) check($sformatf("rdata_r%0d", i), d, e.data);
        check($sformatf("resp_r%0d", i), r, e.resp);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int  c;
        bit  done;
        c    = 0;
        done = 0;
        while (!done && c < budget) begin
            @(negedge sclk);
            c++;
            done = !busy_o && ((s_awvalid_i | s_wvalid_i | s_arvalid_i) == 2'b00)
                   && q0.size() == 0 && q1.size() == 0;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got busy=%0d q0=%0d q1=%0d expected idle within %0d cycles",
                     name, busy_o, q0.size(), q1.size(), budget);
        end
    endtask

    // Slave model plus requester-side valid retirement.
    initial begin : slave_agent
        logic       aw_hs, w_hs, ar_hs, b_hs, r_hs;
        logic       got_aw, got_w;
        logic [AW-1:0] ar_addr;
        logic [1:0] saw, sw, sar;
        got_aw = 1'b0;
        got_w  = 1'b0;
        forever begin
            @(negedge sclk);
            aw_hs   = m_awvalid_o & m_awready_i;
            w_hs    = m_wvalid_o & m_wready_i;
            ar_hs   = m_arvalid_o & m_arready_i;
            b_hs    = m_bvalid_i & m_bready_o;
            r_hs    = m_rvalid_i & m_rready_o;
            ar_addr = m_araddr_o;
            saw     = s_awvalid_i & s_awready_o;
            sw      = s_wvalid_i & s_wready_o;
            sar     = s_arvalid_i & s_arready_o;
            @(posedge sclk);
            #1;
            if (!reset) begin
                m_bvalid_i  = 1'b0;
                m_rvalid_i  = 1'b0;
                m_awready_i = 1'b1;
                got_aw      = 1'b0;
                got_w       = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (saw[i]) s_awvalid_i[i] = 1'b0;
                    if (sw[i])  s_wvalid_i[i]  = 1'b0;
                end
                if (sar[0]) begin
                    if (rdq0.size() > 0) s_araddr_i[31:0] = rdq0.pop_front();
                    else                 s_arvalid_i[0]   = 1'b0;
                end
                if (sar[1]) begin
                    if (rdq1.size() > 0) s_araddr_i[63:32] = rdq1.pop_front();
                    else                 s_arvalid_i[1]    = 1'b0;
                end
                if (b_hs) m_bvalid_i = 1'b0;
                if (r_hs) m_rvalid_i = 1'b0;
                if (aw_hs) got_aw = 1'b1;
                if (w_hs)  got_w  = 1'b1;
                if (got_aw && got_w && !m_bvalid_i) begin
                    m_bvalid_i = 1'b1;
                    m_bresp_i  = slv_bresp;
                    got_aw     = 1'b0;
                    got_w      = 1'b0;
                end
                if (ar_hs) begin
                    m_rvalid_i = 1'b1;
                    m_rdata_i  = rd_table(ar_addr);
                    m_rresp_i  = slv_rresp;
                end
                if (aw_stall > 0) begin
                    m_awready_i = 1'b0;
                    aw_stall--;
                end else begin
                    m_awready_i = 1'b1;
                end
            end
        end
    end

    // Response monitor: pops the granted requester's expectation on every handshake.
    initial begin : monitor
        logic          aw_pend;
        logic [AW-1:0] aw_pend_addr;
        aw_pend = 1'b0;
        aw_pend_addr = '0;
        forever begin
            @(negedge sclk);
            if (reset) begin
                for (int i = 0; i < 2; i++) begin
                    if (s_bvalid_o[i] && s_bready_i[i]) begin
                        check("b_isolation", s_bvalid_o, 2'b01 << i);
                        check("b_other_resp", s_bresp_o[(1-i)*2 +: 2], 2'b00);
                        pop_cmp(i, 1'b0, '0, s_bresp_o[i*2 +: 2]);
                    end
                    if (s_rvalid_o[i] && s_rready_i[i]) begin
                        check("r_isolation", s_rvalid_o, 2'b01 << i);
                        check("r_other_data", s_rdata_o[(1-i)*DW +: DW], '0);
                        pop_cmp(i, 1'b1, s_rdata_o[i*DW +: DW], s_rresp_o[i*2 +: 2]);
                    end
                end
                if (aw_pend) begin
                    check("aw_hold_valid", m_awvalid_o, 1'b1);
                    check("aw_hold_addr", m_awaddr_o, aw_pend_addr);
                end
                aw_pend      = m_awvalid_o && !m_awready_i;
                aw_pend_addr = m_awaddr_o;
            end else begin
                aw_pend = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit         prev_busy;
        int         idle_run;
        int         n_grants;
        logic [1:0] exp_g;
        bit         seen;

        // Reset state
        @(negedge sclk);
        check("rst_handshakes", hs_bundle, '0);
        check("rst_rdata", s_rdata_o, '0);
        check("rst_bresp", {s_bresp_o, s_rresp_o}, '0);
        @(posedge sclk); #2;
        reset = 1'b1;

        // Single write from requester 0, AW and W together
        @(posedge sclk); #2;
        s_awaddr_i[31:0] = 32'h10;
        s_wdata_i[31:0]  = 32'hA5A5A5A5;
        s_wstrb_i[3:0]   = 4'hF;
        slv_bresp        = 2'b00;
        s_awvalid_i[0]   = 1'b1;
        s_wvalid_i[0]    = 1'b1;
        push_exp(0, 1'b0, '0, 2'b00);
        @(negedge sclk);
        check("wr0_not_yet_busy", busy_o, 1'b0);
        @(negedge sclk);
        check("wr0_awvalid", m_awvalid_o, 1'b1);
        check("wr0_wvalid", m_wvalid_o, 1'b1);
        check("wr0_awaddr", m_awaddr_o, 32'h10);
        check("wr0_wdata", m_wdata_o, 32'hA5A5A5A5);
        check("wr0_grant", grant_o, 2'b01);
        wait_idle("wr0", 20);
        check("wr0_busy_fall", busy_o, 1'b0);

        // Requester 1: W three cycles ahead of AW, AW backpressured
        @(posedge sclk); #2;
        s_wdata_i[63:32] = 32'h5A5A0001;
        s_wstrb_i[7:4]   = 4'h3;
        s_wvalid_i[1]    = 1'b1;
        slv_bresp        = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge sclk);
            check("wonly_no_grant", {busy_o, grant_o}, 3'b000);
        end
        @(posedge sclk); #2;
        s_awaddr_i[63:32] = 32'h20;
        s_awvalid_i[1]    = 1'b1;
        aw_stall          = 2;
        push_exp(1, 1'b0, '0, 2'b10);
        @(negedge sclk);
        @(negedge sclk);
        check("wfirst_grant", grant_o, 2'b10);
        check("wfirst_wvalid", m_wvalid_o, 1'b1);
        check("wfirst_awvalid", m_awvalid_o, 1'b1);
        check("wfirst_wdata", {m_wstrb_o, m_wdata_o}, {4'h3, 32'h5A5A0001});
        @(negedge sclk);
        check("wfirst_w_done", {m_wvalid_o, m_awvalid_o}, 2'b01);
        check("wfirst_no_bresp_yet", {busy_o, s_bvalid_o}, 3'b100);
        wait_idle("wfirst", 20);

        // Contention straight out of reset: requester 0 first
        @(posedge sclk); #2;
        reset = 1'b0;
        repeat (2) @(posedge sclk);
        #2;
        reset       = 1'b1;
        slv_rresp   = 2'b00;
        s_araddr_i  = {32'h8, 32'h4};
        s_arvalid_i = 2'b11;
        push_exp(0, 1'b1, 32'h11111111, 2'b00);
        push_exp(1, 1'b1, 32'h22222222, 2'b00);
        served.delete();
        @(negedge sclk);
        @(negedge sclk);
        check("cont_first_grant", grant_o, 2'b01);
        check("cont_araddr", m_araddr_o, 32'h4);
        wait_idle("cont", 30);
        check("cont_order", (served.size() == 2) ? served[0] * 2 + served[1] : 99, 1);

        // Fairness: 4 back-to-back reads from each requester
        @(posedge sclk); #2;
        s_araddr_i = {f_addr1[0], f_addr0[0]};
        for (int k = 1; k < 4; k++) begin
            rdq0.push_back(f_addr0[k]);
            rdq1.push_back(f_addr1[k]);
        end
        for (int k = 0; k < 4; k++) begin
            push_exp(0, 1'b1, f_data0[k], 2'b00);
            push_exp(1, 1'b1, f_data1[k], 2'b00);
        end
        s_arvalid_i = 2'b11;
        prev_busy = 1'b0;
        idle_run  = 0;
        n_grants  = 0;
        exp_g     = 2'b01;
        for (int c = 0; c < 60 && n_grants < 8; c++) begin
            @(negedge sclk);
            if (busy_o && !prev_busy) begin
                check("fair_grant", grant_o, exp_g);
                if (n_grants > 0) check("fair_gap", idle_run, 1);
                exp_g    = {exp_g[0], exp_g[1]};
                n_grants++;
                idle_run = 0;
            end else if (!busy_o) begin
                idle_run++;
            end
            prev_busy = busy_o;
        end
        check("fair_count", n_grants, 8);
        wait_idle("fair", 30);

        // Write precedence over read, AW held off for 5 cycles
        @(posedge sclk); #2;
        s_awaddr_i[31:0] = 32'h40;
        s_wdata_i[31:0]  = 32'h12345678;
        s_wstrb_i[3:0]   = 4'hC;
        s_araddr_i[31:0] = 32'h8;
        slv_bresp        = 2'b01;
        slv_rresp        = 2'b10;
        aw_stall         = 5;
        s_awvalid_i[0]   = 1'b1;
        s_wvalid_i[0]    = 1'b1;
        s_arvalid_i[0]   = 1'b1;
        push_exp(0, 1'b0, '0, 2'b01);
        push_exp(0, 1'b1, 32'h22222222, 2'b10);
        served.delete();
        @(negedge sclk);
        @(negedge sclk);
        check("prec_awvalid", m_awvalid_o, 1'b1);
        check("prec_no_arvalid", m_arvalid_o, 1'b0);
        check("prec_wstrb", m_wstrb_o, 4'hC);
        wait_idle("prec", 40);
        check("prec_served", served.size(), 2);

        // Reset while requester 1 sits in RDATA
        @(posedge sclk); #2;
        slv_rresp         = 2'b00;
        s_rready_i        = 2'b01;
        s_araddr_i[63:32] = 32'h4;
        s_arvalid_i[1]    = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge sclk);
            seen = s_rvalid_o[1];
        end
        check("rst_mid_in_rdata", s_rvalid_o, 2'b10);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_handshakes", hs_bundle, '0);
        check("rst_mid_data", {s_rdata_o, m_araddr_o}, '0);
        @(posedge sclk); #2;
        s_arvalid_i = 2'b00;
        s_rready_i  = 2'b11;
        @(posedge sclk); #2;
        reset       = 1'b1;
        s_araddr_i  = {32'h8, 32'h4};
        s_arvalid_i = 2'b11;
        push_exp(0, 1'b1, 32'h11111111, 2'b00);
        push_exp(1, 1'b1, 32'h22222222, 2'b00);
        served.delete();
        @(negedge sclk);
        @(negedge sclk);
        check("rst_prio_grant", grant_o, 2'b01);
        wait_idle("rst_prio", 30);
        check("rst_prio_order", (served.size() == 2) ? served[0] * 2 + served[1] : 99, 1);

        check("queues_drained", q0.size() + q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
